// File: rtl/regs_arb_pkg.sv
// Shared definitions for the two-requester register-file port arbiter:
// FSM state encoding, requester count and default data/address widths.
package regs_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/regs_arb_pick.sv
// Winner selection for two requesters. A lone request always wins; on a tie
// the requester that did not win last time gets the grant. The "last" input
// is the index of the previous winner (0 = core, 1 = debug). Driving it
// constantly with 1 turns the tie rule into fixed priority for requester 0.
module regs_arb_pick
  import regs_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] gnt
);

  // One-hot grant from the request vector and the previous winner.
  always_comb begin
    gnt = '0;
    if (req[0] && req[1]) begin
      gnt = last ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/regs_port_arb.sv
// Arbiter sharing one register-file port pair between the core (requester 0)
// and the debug unit (requester 1).
//
// Handshake: a requester raises req_i with its command fields stable and
// keeps them until gnt_i is seen; it may drop req_i during the gnt cycle or
// keep it high to present the next command. Dropping req_i before gnt_i
// withdraws the command. done_i pulses one cycle after the DONE state; read
// results are valid in rdata_*_i from that pulse until the next read of the
// same requester completes.
//
// Timing: request sampled at edge E0 -> ISSUE (gnt, rf_we) during E0..E1,
// DONE during E1..E2 (register file presents read data), done pulse E2..E3.
//
// Build option: define REGS_ARB_RR_EN for two-way round-robin on ties;
// without it requester 0 always wins a tie.
module regs_port_arb
  import regs_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 (core)
  input  logic              req_0,
  input  logic              wr_0,
  input  logic [ADDR_W-1:0] addr_a_0,
  input  logic [ADDR_W-1:0] addr_b_0,
  input  logic [DATA_W-1:0] wdata_0,
  output logic              gnt_0,
  output logic              done_0,
  output logic [DATA_W-1:0] rdata_a_0,
  output logic [DATA_W-1:0] rdata_b_0,
  // requester 1 (debug)
  input  logic              req_1,
  input  logic              wr_1,
  input  logic [ADDR_W-1:0] addr_a_1,
  input  logic [ADDR_W-1:0] addr_b_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_1,
  output logic              done_1,
  output logic [DATA_W-1:0] rdata_a_1,
  output logic [DATA_W-1:0] rdata_b_1,
  // register-file side
  output logic [ADDR_W-1:0] rf_rnum_A,
  output logic [ADDR_W-1:0] rf_rnum_B,
  output logic [ADDR_W-1:0] rf_wnum,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata_A,
  input  logic [DATA_W-1:0] rf_rdata_B,
  output logic              busy
);

  state_t              state;
  state_t              state_nxt;
  logic [NUM_REQ-1:0]  req_vec;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                last;
  logic                start;

  // Latched command of the current winner.
  logic                lat_win;
  logic                lat_wr;
  logic [ADDR_W-1:0]   lat_a;
  logic [ADDR_W-1:0]   lat_b;
  logic [DATA_W-1:0]   lat_d;

  assign req_vec = {req_1, req_0};

`ifdef REGS_ARB_RR_EN
  // The latched winner index doubles as the round-robin pointer: it is
  // reloaded on every ISSUE entry and resets to 1 so requester 0 wins the
  // first tie.
  assign last = lat_win;
`else
  assign last = 1'b1;
`endif

  regs_arb_pick u_pick (
    .req  (req_vec),
    .last (last),
    .gnt  (pick_gnt)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: ISSUE and DONE are single cycles; DONE chains straight into
  // a new ISSUE when any request is pending.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (|pick_gnt) ? ISSUE : IDLE;
      ISSUE:   state_nxt = DONE;
      DONE:    state_nxt = (|pick_gnt) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign start = (state_nxt == ISSUE);

  // Capture the winner and its command fields on every ISSUE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_win <= 1'b1;
      lat_wr  <= 1'b0;
      lat_a   <= '0;
      lat_b   <= '0;
      lat_d   <= '0;
    end else if (start) begin
      lat_win <= pick_gnt[1];
      if (pick_gnt[1]) begin
        lat_wr <= wr_1;
        lat_a  <= addr_a_1;
        lat_b  <= addr_b_1;
        lat_d  <= wdata_1;
      end else begin
        lat_wr <= wr_0;
        lat_a  <= addr_a_0;
        lat_b  <= addr_b_0;
        lat_d  <= wdata_0;
      end
    end
  end

  // Grants and write enable are decoded from the state register, so an
  // asynchronous reset during ISSUE removes them immediately.
  assign gnt_0 = (state == ISSUE) && !lat_win;
  assign gnt_1 = (state == ISSUE) &&  lat_win;
  assign rf_we = (state == ISSUE) &&  lat_wr;
  assign busy  = (state != IDLE);

  // Register-file numbers and write data follow the latched command and
  // therefore hold their last values outside ISSUE.
  assign rf_wnum   = lat_a;
  assign rf_rnum_A = lat_a;
  assign rf_rnum_B = lat_b;
  assign rf_wdata  = lat_d;

  // Completion pulse one cycle after DONE, and read-data capture at the
  // DONE-exit edge for the winning requester on reads only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_0    <= 1'b0;
      done_1    <= 1'b0;
      rdata_a_0 <= '0;
      rdata_b_0 <= '0;
      rdata_a_1 <= '0;
      rdata_b_1 <= '0;
    end else begin
      done_0 <= (state == DONE) && !lat_win;
      done_1 <= (state == DONE) &&  lat_win;
      if ((state == DONE) && !lat_wr) begin
        if (lat_win) begin
          rdata_a_1 <= rf_rdata_A;
          rdata_b_1 <= rf_rdata_B;
        end else begin
          rdata_a_0 <= rf_rdata_A;
          rdata_b_0 <= rf_rdata_B;
        end
      end
    end
  end

endmodule

// File: tb/tb_regs_port_arb.sv
// Bench for regs_port_arb: a behavioural register file on the rf_* side,
// directed timing scenarios, then concurrent randomized traffic. Each issued
// command pushes the read data its requester must show after done_i; a
// monitor pops and compares on every done pulse.
module tb_regs_port_arb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          req_0, wr_0, req_1, wr_1;
  logic [AW-1:0] addr_a_0, addr_b_0, addr_a_1, addr_b_1;
  logic [DW-1:0] wdata_0, wdata_1;
  logic          gnt_0, done_0, gnt_1, done_1;
  logic [DW-1:0] rdata_a_0, rdata_b_0, rdata_a_1, rdata_b_1;
  logic [AW-1:0] rf_rnum_A, rf_rnum_B, rf_wnum;
  logic [DW-1:0] rf_wdata, rf_rdata_A, rf_rdata_B;
  logic          rf_we, busy;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0]   model_regs [32];
  logic [DW-1:0]   hold_a [2];
  logic [DW-1:0]   hold_b [2];
  logic [2*DW-1:0] exp_q0 [$];
  logic [2*DW-1:0] exp_q1 [$];
  logic [2*DW-1:0] e0, e1;

  // environment register file
  logic [DW-1:0] rf_mem [32];

  regs_port_arb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .wr_0(wr_0), .addr_a_0(addr_a_0), .addr_b_0(addr_b_0),
    .wdata_0(wdata_0), .gnt_0(gnt_0), .done_0(done_0),
    .rdata_a_0(rdata_a_0), .rdata_b_0(rdata_b_0),
    .req_1(req_1), .wr_1(wr_1), .addr_a_1(addr_a_1), .addr_b_1(addr_b_1),
    .wdata_1(wdata_1), .gnt_1(gnt_1), .done_1(done_1),
    .rdata_a_1(rdata_a_1), .rdata_b_1(rdata_b_1),
    .rf_rnum_A(rf_rnum_A), .rf_rnum_B(rf_rnum_B), .rf_wnum(rf_wnum),
    .rf_wdata(rf_wdata), .rf_we(rf_we),
    .rf_rdata_A(rf_rdata_A), .rf_rdata_B(rf_rdata_B), .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // register file: r0 reads as zero and ignores writes; reads registered
  always @(posedge clk) begin
    if (rf_we) begin
      if (rf_wnum != 0) rf_mem[rf_wnum] <= rf_wdata;
    end else begin
      rf_rdata_A <= rf_mem[rf_rnum_A];
      rf_rdata_B <= rf_mem[rf_rnum_B];
    end
  end

  task automatic chk(input string name, input logic [2*DW-1:0] act,
                     input logic [2*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: apply a command in program order and queue the read
  // data the requester must present after its done pulse.
  function automatic void push_exp(input int r, input bit wr,
                                   input logic [AW-1:0] a, input logic [AW-1:0] b,
                                   input logic [DW-1:0] d);
    if (wr) begin
      if (a != 0) model_regs[a] = d;
    end else begin
      hold_a[r] = model_regs[a];
      hold_b[r] = model_regs[b];
    end
    if (r == 0) exp_q0.push_back({hold_a[0], hold_b[0]});
    else        exp_q1.push_back({hold_a[1], hold_b[1]});
  endfunction

  // driver tasks
  task automatic set_req(input int r, input bit rq, input bit wr,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d);
    if (r == 0) begin
      req_0 = rq; wr_0 = wr; addr_a_0 = a; addr_b_0 = b; wdata_0 = d;
    end else begin
      req_1 = rq; wr_1 = wr; addr_a_1 = a; addr_b_1 = b; wdata_1 = d;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and wait (bounded) for its grant.
  task automatic run_op(input int r, input bit wr, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [DW-1:0] d);
    int  t;
    bit  got;
    t   = 0;
    got = 0;
    push_exp(r, wr, a, b, d);
    set_req(r, 1'b1, wr, a, b, d);
    while (!got && t < 1000) begin
      cyc();
      t++;
      got = (r == 0) ? gnt_0 : gnt_1;
    end
    chk($sformatf("gnt_wait_%0d", r), {63'd0, got}, 64'd1);
    set_req(r, 1'b0, wr, a, b, d);
  endtask

  // Single command from idle with cycle-exact checks of the handshake.
  task automatic timed_op(input int r, input bit wr, input logic [AW-1:0] a,
                          input logic [AW-1:0] b, input logic [DW-1:0] d);
    logic [1:0] oh;
    oh = (r == 0) ? 2'b01 : 2'b10;
    push_exp(r, wr, a, b, d);
    set_req(r, 1'b1, wr, a, b, d);
    cyc();
    chk("c1_gnt", {62'd0, gnt_1, gnt_0}, {62'd0, oh});
    chk("c1_we", {63'd0, rf_we}, {63'd0, wr});
    chk("c1_busy", {63'd0, busy}, 64'd1);
    chk("c1_rnum", {54'd0, rf_rnum_A, rf_rnum_B}, {54'd0, a, b});
    if (wr) chk("c1_wport", {27'd0, rf_wnum, rf_wdata}, {27'd0, a, d});
    set_req(r, 1'b0, wr, a, b, d);
    cyc();
    chk("c2_gnt_we", {61'd0, gnt_1, gnt_0, rf_we}, 64'd0);
    chk("c2_busy", {63'd0, busy}, 64'd1);
    chk("c2_rnum_hold", {54'd0, rf_rnum_A, rf_rnum_B}, {54'd0, a, b});
    chk("c2_done", {62'd0, done_1, done_0}, 64'd0);
    cyc();
    chk("c3_done", {62'd0, done_1, done_0}, {62'd0, oh});
    chk("c3_busy", {63'd0, busy}, 64'd0);
    cyc();
    chk("c4_done", {62'd0, done_1, done_0}, 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_0) begin
        if (exp_q0.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_0_unexpected: got done_0=1 required no pending command");
        end else begin
          e0 = exp_q0.pop_front();
          chk("rdata_0", {rdata_a_0, rdata_b_0}, e0);
        end
      end
      if (done_1) begin
        if (exp_q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL done_1_unexpected: got done_1=1 required no pending command");
        end else begin
          e1 = exp_q1.pop_front();
          chk("rdata_1", {rdata_a_1, rdata_b_1}, e1);
        end
      end
    end
  end

  initial begin
    int w;
    for (int i = 0; i < 32; i++) begin
      model_regs[i] = '0;
      rf_mem[i]     = '0;
    end
    for (int i = 0; i < 2; i++) begin
      hold_a[i] = '0;
      hold_b[i] = '0;
    end
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);

    // reset state
    #2;
    chk("rst_ctl", {58'd0, gnt_0, gnt_1, done_0, done_1, rf_we, busy}, 64'd0);
    chk("rst_rdata0", {rdata_a_0, rdata_b_0}, 64'd0);
    chk("rst_rdata1", {rdata_a_1, rdata_b_1}, 64'd0);
    chk("rst_rf", {17'd0, rf_rnum_A, rf_rnum_B, rf_wnum, rf_wdata}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // core write r5, then read r5 / r0
    timed_op(0, 1'b1, 5'd5, 5'd0, 32'h0000_00A5);
    run_op(0, 1'b0, 5'd5, 5'd0, 32'h0);
    repeat (4) cyc();

    // both requesters hold reads continuously
    set_req(0, 1'b1, 1'b0, 5'd0, 5'd0, '0);
    set_req(1, 1'b1, 1'b0, 5'd0, 5'd0, '0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      if (i % 2 == 0) begin
`ifdef REGS_ARB_RR_EN
        w = ((i / 2) % 2 == 0) ? 1 : 0;
`else
        w = 0;
`endif
        chk($sformatf("cont_gnt_%0d", i), {62'd0, gnt_1, gnt_0},
            (w == 0) ? 64'd1 : 64'd2);
        push_exp(w, 1'b0, 5'd0, 5'd0, '0);
      end else begin
        chk($sformatf("cont_gap_%0d", i), {62'd0, gnt_1, gnt_0}, 64'd0);
      end
    end
    set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, '0);
    set_req(1, 1'b0, 1'b0, 5'd0, 5'd0, '0);
    repeat (4) cyc();

    // debug write r0 (discarded by the file), then read r0
    timed_op(1, 1'b1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    timed_op(1, 1'b0, 5'd0, 5'd0, 32'h0);
    repeat (2) cyc();

    // req_1 pulsed for one cycle while the core is being served
    push_exp(0, 1'b1, 5'd3, 5'd0, 32'h0000_3333);
    set_req(0, 1'b1, 1'b1, 5'd3, 5'd0, 32'h0000_3333);
    cyc();
    chk("pulse_gnt0", {62'd0, gnt_1, gnt_0}, 64'd1);
    set_req(0, 1'b0, 1'b1, 5'd3, 5'd0, 32'h0000_3333);
    set_req(1, 1'b1, 1'b0, 5'd3, 5'd3, '0);
    cyc();
    set_req(1, 1'b0, 1'b0, 5'd3, 5'd3, '0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("pulse_no_gnt1_%0d", i), {62'd0, gnt_1, done_1}, 64'd0);
    end

    // reset during an ISSUE write of r7
    set_req(0, 1'b1, 1'b1, 5'd7, 5'd0, 32'h0000_1234);
    cyc();
    chk("rst_issue_we", {62'd0, gnt_0, rf_we}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_issue_drop", {61'd0, rf_we, gnt_0, busy}, 64'd0);
    set_req(0, 1'b0, 1'b0, 5'd0, 5'd0, '0);
    for (int i = 0; i < 2; i++) begin
      hold_a[i] = '0;
      hold_b[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("rst_no_done_%0d", i), {62'd0, done_0, busy}, 64'd0);
    end
    run_op(0, 1'b0, 5'd7, 5'd5, 32'h0);
    repeat (4) cyc();

    // concurrent randomized traffic; core owns r1..r15, debug r16..r31
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(3, 0)) cyc();
          run_op(0, 1'($urandom_range(1, 0)), 5'($urandom_range(15, 0)),
                 5'($urandom_range(15, 0)), $urandom);
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(3, 0)) cyc();
          run_op(1, 1'($urandom_range(1, 0)),
                 ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 16)),
                 5'($urandom_range(31, 16)), $urandom);
        end
      end
    join

    // drain
    for (int t = 0; t < 200 && (exp_q0.size() != 0 || exp_q1.size() != 0); t++) cyc();
    chk("drain_q0", 64'(exp_q0.size()), 64'd0);
    chk("drain_q1", 64'(exp_q1.size()), 64'd0);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
